// File: rtl/csr_latch_pkg.sv
// Shared encodings for the clocked SR latch driver: command ops, FSM states,
// counter widths and the readback rule applied in CHECK.
package csr_latch_pkg;

    localparam int CNT_W     = 4;
    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_SET    = 2'b01,
        OP_RESET  = 2'b10,
        OP_FORBID = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4
    } state_e;

    // Down-counter load value for a phase lasting n cycles.
    function automatic logic [CNT_W-1:0] cnt_load(input int n);
        return CNT_W'(n - 1);
    endfunction

    // Readback is wrong if the latch did not take the commanded value, a HOLD
    // disturbed it, or the op was never legal in the first place.
    function automatic logic readback_err(input op_e op, input logic q_now,
                                          input logic q_at_hs);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_SET:    bad = (q_now != 1'b1);
            OP_RESET:  bad = (q_now != 1'b0);
            OP_HOLD:   bad = (q_now != q_at_hs);
            OP_FORBID: bad = 1'b1;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/csr_latch_driver_if.sv
// Command/status bundle between a CSR master and the latch driver.
interface csr_latch_driver_if;
    import csr_latch_pkg::*;

    logic                 req_valid;
    logic [1:0]           req_op;
    logic                 req_ready;
    logic                 done;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output req_valid, req_op,
        input  req_ready, done, err, err_cnt
    );

    modport slave (
        input  req_valid, req_op,
        output req_ready, done, err, err_cnt
    );
endinterface

// File: rtl/csr_latch_driver.sv
// Sequences S_n/R_n and the C strobe of an external clocked SR latch with
// programmable setup/pulse/hold windows, then checks the latch readback.
module csr_latch_driver
    import csr_latch_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    csr_latch_driver_if.slave   bus,
    output logic                C,
    output logic                S,
    output logic                R,
    input  logic                q_fb
);

    localparam logic [CNT_W-1:0] SETUP_LD = cnt_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] PULSE_LD = cnt_load(PULSE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = cnt_load(HOLD_CYC);

    state_e               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    op_e                  op_reg;
    logic                 q_hs_reg;
    logic                 c_reg;
    logic                 s_reg;
    logic                 r_reg;
    logic                 ready_reg;
    logic                 done_reg;
    logic                 err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    op_e  req_op;
    logic handshake;
    logic check_err;

    assign req_op    = op_e'(bus.req_op);
    assign handshake = ready_reg & bus.req_valid;
    assign check_err = readback_err(op_reg, q_fb, q_hs_reg);

    // Single FSM: all outputs are registered so C/S/R never glitch at the latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            op_reg      <= OP_HOLD;
            q_hs_reg    <= 1'b0;
            c_reg       <= 1'b0;
            s_reg       <= 1'b1;
            r_reg       <= 1'b1;
            ready_reg   <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    ready_reg <= 1'b1;
                    if (handshake) begin
                        op_reg    <= req_op;
                        q_hs_reg  <= q_fb;
                        ready_reg <= 1'b0;
                        // FORBIDDEN maps to S=R=1 here, so both inputs are never low.
                        s_reg     <= (req_op != OP_SET);
                        r_reg     <= (req_op != OP_RESET);
                        if (req_op == OP_FORBID) begin
                            state_reg <= ST_CHECK;
                        end else begin
                            state_reg <= ST_SETUP;
                            cnt_reg   <= SETUP_LD;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_PULSE;
                        cnt_reg   <= PULSE_LD;
                        c_reg     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= HOLD_LD;
                        c_reg     <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_CHECK;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_CHECK: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    s_reg     <= 1'b1;
                    r_reg     <= 1'b1;
                    done_reg  <= 1'b1;
                    err_reg   <= check_err;
                    if (check_err && (err_cnt_reg != ERR_CNT_MAX)) begin
                        err_cnt_reg <= err_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    c_reg     <= 1'b0;
                    s_reg     <= 1'b1;
                    r_reg     <= 1'b1;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign C             = c_reg;
    assign S             = s_reg;
    assign R             = r_reg;
    assign bus.req_ready = ready_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_csr_latch_driver.sv
// Scoreboard bench for csr_latch_driver driving a behavioural clocked SR latch.
module tb_csr_latch_driver;

    localparam int SC  = 2;
    localparam int PC  = 4;
    localparam int HC  = 2;
    localparam int LAT = SC + PC + HC + 1;

    typedef struct {
        int exp_cyc;
        bit exp_err;
        int exp_cnt;
        bit exp_q;
        int exp_c;
    } exp_t;

    logic clk;
    logic rst_n;
    logic C, S, R;
    logic q_fb;
    logic latch_q;
    logic force_q0;

    csr_latch_driver_if bus();

    csr_latch_driver #(.SETUP_CYC(SC), .PULSE_CYC(PC), .HOLD_CYC(HC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .C     (C),
        .S     (S),
        .R     (R),
        .q_fb  (q_fb)
    );

    // Behavioural clocked SR latch with active-low S/R.
    always @(C or S or R) begin
        if (C) begin
            if (!S && R)      latch_q = 1'b1;
            else if (S && !R) latch_q = 1'b0;
        end
    end
    assign q_fb = force_q0 ? 1'b0 : latch_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    // Reference state: latch value and saturating error total.
    bit m_q       = 1'b0;
    int err_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    int c_cnt  = 0;
    bit sr_bad = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            c_cnt  = 0;
            sr_bad = 1'b0;
        end else begin
            if (C) c_cnt++;
            if (!S && !R) sr_bad = 1'b1;
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_latency", cyc, e.exp_cyc);
                    chk("err", int'(bus.err), int'(e.exp_err));
                    chk("err_cnt", int'(bus.err_cnt), e.exp_cnt);
                    chk("q_fb", int'(q_fb), int'(e.exp_q));
                    chk("c_cycles", c_cnt, e.exp_c);
                    chk("sr_both_low", int'(sr_bad), 0);
                    chk("sr_idle", int'({S, R, C}), 3'b110);
                end
                c_cnt  = 0;
                sr_bad = 1'b0;
            end else if (bus.err) begin
                chk("err_without_done", 1, 0);
            end
        end
    end

    // Offer one op; returns right after the handshake (plus 'extra' ignored cycles).
    task automatic issue(input logic [1:0] op, input bit frc, input int extra);
        int   waited;
        exp_t e;
        bit   q_at_hs;
        tick();
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.req_ready) begin
            chk("ready_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        force_q0 = frc;
        q_at_hs  = frc ? 1'b0 : m_q;
        if (op == 2'b01) m_q = 1'b1;
        if (op == 2'b10) m_q = 1'b0;
        e.exp_err = (op == 2'b11) || (op == 2'b01 && frc) ||
                    (op == 2'b10 && !frc && m_q) ||
                    (op == 2'b00 && ((frc ? 1'b0 : m_q) != q_at_hs));
        if (e.exp_err && err_total < 255) err_total++;
        e.exp_cyc = cyc + 1 + ((op == 2'b11) ? 1 : LAT);
        e.exp_cnt = err_total;
        e.exp_q   = frc ? 1'b0 : m_q;
        e.exp_c   = (op == 2'b11) ? 0 : PC;
        sb_q.push_back(e);
        tick();
        repeat (extra) begin
            bus.req_op = 2'($urandom_range(0, 3));
            tick();
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            tick();
            waited++;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        force_q0      = 1'b0;
        latch_q       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        repeat (3) tick();
        chk("rst_C", int'(C), 0);
        chk("rst_S", int'(S), 1);
        chk("rst_R", int'(R), 1);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_err_cnt", int'(bus.err_cnt), 0);
        chk("rst_ready", int'(bus.req_ready), 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", int'(bus.req_ready), 1);

        // SET with defaults, then SET/RESET back-to-back.
        issue(2'b01, 1'b0, 0);
        drain();
        issue(2'b01, 1'b0, 3);
        issue(2'b10, 1'b0, 0);
        drain();
        // FORBIDDEN: first error since reset.
        issue(2'b11, 1'b0, 0);
        drain();
        // HOLD after SET must not disturb the latch.
        issue(2'b01, 1'b0, 0);
        issue(2'b00, 1'b0, 5);
        drain();

        // Reset while C is high.
        issue(2'b01, 1'b0, 0);
        begin
            int waited;
            waited = 0;
            while (!C && waited < 20) begin
                tick();
                waited++;
            end
            chk("c_seen_before_abort", int'(C), 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_C", int'(C), 0);
        chk("abort_SR", int'({S, R}), 2'b11);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_err_cnt", int'(bus.err_cnt), 0);
        sb_q.delete();
        err_total = 0;
        m_q       = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("abort_no_pending", sb_q.size(), 0);
        issue(2'b10, 1'b0, 0);
        issue(2'b01, 1'b0, 0);
        drain();

        // Randomized mix of ops, forced readback faults and ignored valid.
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            issue(op, ($urandom_range(0, 9) == 0), (op == 2'b11) ? 0 : int'($urandom_range(0, 6)));
        end
        drain();

        // Forced SET failures drive the error counter into saturation.
        for (int i = 0; i < 300; i++) begin
            issue(2'b01, 1'b1, 0);
        end
        drain();
        force_q0 = 1'b0;
        chk("err_cnt_saturated", int'(bus.err_cnt), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
